// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU execute stage.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_SHR  = 4'd6,
        OP_PASS = 4'd7,
        OP_MUL  = 4'd8,
        OP_DIV  = 4'd9,
        OP_MOD  = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // Bit positions inside flags_o = {z,c,n,v}.
    localparam int FLG_Z = 3;
    localparam int FLG_C = 2;
    localparam int FLG_N = 1;
    localparam int FLG_V = 0;

    // Opcodes handled by the iterative multiply/divide unit.
    function automatic logic is_seq_op(input logic [3:0] op);
        return (op >= 4'(OP_MUL)) && (op <= 4'(OP_MOD));
    endfunction

    // Opcodes 11-15 are illegal.
    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= 4'(OP_MOD);
    endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Request/writeback bundle between the issue logic and the execute stage.
interface alu_exec_stage_if #(
    parameter int W  = 8,
    parameter int AW = 3
);
    logic          start_i;
    logic [3:0]    op_i;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic [AW-1:0] rd_i;
    logic          busy_o;
    logic          we_o;
    logic [AW-1:0] rd_o;
    logic [W-1:0]  dat_o;
    logic [3:0]    flags_o;
    logic          err_o;

    modport master (
        output start_i, op_i, a_i, b_i, rd_i,
        input  busy_o, we_o, rd_o, dat_o, flags_o, err_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, rd_i,
        output busy_o, we_o, rd_o, dat_o, flags_o, err_o
    );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative W-cycle shift-add multiplier and restoring divider.
// hi/lo hold {product high, product low} for MUL and {remainder, quotient}
// for DIV/MOD. The *_nxt outputs expose the result of the iteration taking
// place at the coming edge so the owner can capture the final value directly.
module alu_seq_muldiv #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cen,
    input  logic         load_i,
    input  logic         run_i,
    input  logic         is_mul_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] hi_nxt_o,
    output logic [W-1:0] lo_nxt_o,
    output logic         done_o
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  opnd_q, opnd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_mul_q, is_mul_d;

    logic [W:0]    mul_sum;
    logic [W:0]    div_shift;
    logic          div_fits;
    logic [W-1:0]  step_hi;
    logic [W-1:0]  step_lo;

    // One multiply or divide iteration on the current register contents.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[W-1]};
        div_fits  = div_shift >= {1'b0, opnd_q};
        if (is_mul_q) begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], lo_q[W-1:1]};
        end else if (div_fits) begin
            step_hi = W'(div_shift - {1'b0, opnd_q});
            step_lo = {lo_q[W-2:0], 1'b1};
        end else begin
            step_hi = div_shift[W-1:0];
            step_lo = {lo_q[W-2:0], 1'b0};
        end
    end

    assign hi_nxt_o = step_hi;
    assign lo_nxt_o = step_lo;
    assign done_o   = run_i && (cnt_q == CW'(W - 1));

    // Load operands on accept, otherwise step once per enabled ITER cycle.
    always_comb begin
        // NOTE: every next-state variable starts from its held value so no path leaves it unassigned (no latch).
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        is_mul_d = is_mul_q;
        if (cen) begin
            if (load_i) begin
                hi_d     = '0;
                lo_d     = is_mul_i ? b_i : a_i;
                opnd_d   = is_mul_i ? a_i : b_i;
                cnt_d    = '0;
                is_mul_d = is_mul_i;
            end else if (run_i) begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            is_mul_q <= is_mul_d;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle ALU ops, iterative MUL/DIV/MOD, one-cycle
// writeback strobe into the register file and a {z,c,n,v} flags register.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    alu_exec_stage_if.slave   bus
);
    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [W-1:0]  dat_q, dat_d;
    logic [3:0]    flags_q, flags_d;
    op_e           op_q, op_d;
    logic [AW-1:0] rd_pend_q, rd_pend_d;
    logic          div0_q, div0_d;

    logic [W:0]    sum_ext;
    logic [W:0]    diff_ext;
    logic [W-1:0]  alu_res;
    logic          alu_c;
    logic          alu_v;

    logic          seq_load;
    logic          seq_done;
    logic [W-1:0]  seq_hi;
    logic [W-1:0]  seq_lo;
    logic [W-1:0]  seq_res;
    logic          seq_c;
    logic          seq_v;

    alu_seq_muldiv #(.W(W)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .load_i   (seq_load),
        .run_i    (state_q == ST_ITER),
        .is_mul_i (bus.op_i == 4'(OP_MUL)),
        .a_i      (bus.a_i),
        .b_i      (bus.b_i),
        .hi_nxt_o (seq_hi),
        .lo_nxt_o (seq_lo),
        .done_o   (seq_done)
    );

    // Single-cycle ALU on the live request operands.
    always_comb begin
        sum_ext  = {1'b0, bus.a_i} + {1'b0, bus.b_i};
        diff_ext = {1'b0, bus.a_i} - {1'b0, bus.b_i};
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (bus.op_i)
            OP_ADD: begin
                alu_res = sum_ext[W-1:0];
                alu_c   = sum_ext[W];
                alu_v   = (bus.a_i[W-1] == bus.b_i[W-1]) && (sum_ext[W-1] != bus.a_i[W-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[W-1:0];
                alu_c   = diff_ext[W];
                alu_v   = (bus.a_i[W-1] != bus.b_i[W-1]) && (diff_ext[W-1] != bus.a_i[W-1]);
            end
            OP_AND:  alu_res = bus.a_i & bus.b_i;
            OP_OR:   alu_res = bus.a_i | bus.b_i;
            OP_XOR:  alu_res = bus.a_i ^ bus.b_i;
            OP_SHL: begin
                alu_res = {bus.a_i[W-2:0], 1'b0};
                alu_c   = bus.a_i[W-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, bus.a_i[W-1:1]};
                alu_c   = bus.a_i[0];
            end
            OP_PASS: alu_res = bus.b_i;
            default: alu_res = '0;
        endcase
    end

    // Final MUL/DIV/MOD result and its carry/overflow flags.
    always_comb begin
        seq_res = (op_q == OP_MOD) ? seq_hi : seq_lo;
        seq_c   = (op_q == OP_MUL) && (seq_hi != '0);
        seq_v   = (op_q != OP_MUL) && div0_q;
    end

    // FSM next state and registered outputs; nothing moves while cen=0.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        err_d     = err_q;
        rd_d      = rd_q;
        dat_d     = dat_q;
        flags_d   = flags_q;
        op_d      = op_q;
        rd_pend_d = rd_pend_q;
        div0_d    = div0_q;
        seq_load  = 1'b0;
        if (cen) begin
            we_d  = 1'b0;
            err_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        if (is_seq_op(bus.op_i)) begin
                            op_d      = op_e'(bus.op_i);
                            rd_pend_d = bus.rd_i;
                            div0_d    = (bus.b_i == '0);
                            seq_load  = 1'b1;
                            state_d   = ST_ITER;
                        end else if (is_legal_op(bus.op_i)) begin
                            dat_d          = alu_res;
                            rd_d           = bus.rd_i;
                            flags_d[FLG_Z] = (alu_res == '0);
                            flags_d[FLG_C] = alu_c;
                            flags_d[FLG_N] = alu_res[W-1];
                            flags_d[FLG_V] = alu_v;
                            we_d           = 1'b1;
                            state_d        = ST_WB;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_ITER: begin
                    if (seq_done) begin
                        dat_d          = seq_res;
                        rd_d           = rd_pend_q;
                        flags_d[FLG_Z] = (seq_res == '0);
                        flags_d[FLG_C] = seq_c;
                        flags_d[FLG_N] = seq_res[W-1];
                        flags_d[FLG_V] = seq_v;
                        we_d           = 1'b1;
                        state_d        = ST_WB;
                    end
                end
                ST_WB:   state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            rd_q      <= '0;
            dat_q     <= '0;
            flags_q   <= '0;
            op_q      <= OP_ADD;
            rd_pend_q <= '0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
            dat_q     <= dat_d;
            flags_q   <= flags_d;
            op_q      <= op_d;
            rd_pend_q <= rd_pend_d;
            div0_q    <= div0_d;
        end
    end

    assign bus.busy_o  = (state_q != ST_IDLE);
    assign bus.we_o    = we_q;
    assign bus.err_o   = err_q;
    assign bus.rd_o    = rd_q;
    assign bus.dat_o   = dat_q;
    assign bus.flags_o = flags_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage with hand-computed results.
module tb_alu_exec_stage;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    logic cen;
    int   checks;
    int   errors;

    alu_exec_stage_if #(.W(8), .AW(3)) bus ();

    alu_exec_stage #(.W(8), .AW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op; track writeback latency (negedges after the accept edge),
    // optionally poke a start_i while busy and/or drop cen for 3 cycles.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [7:0] a, input logic [7:0] b, input logic [2:0] rd,
                          input logic [7:0] exp_dat, input logic [3:0] exp_flg,
                          input int exp_lat, input bit inject, input int cen_at);
        int  k;
        bit  seen;
        int  busy_bad;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.rd_i    = rd;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.op_i    = 4'd0;
        bus.a_i     = ~a;
        bus.b_i     = ~b;
        bus.rd_i    = ~rd;
        k        = 0;
        seen     = 1'b0;
        busy_bad = 0;
        while (!seen && k < 40) begin
            if (bus.we_o) begin
                seen = 1'b1;
            end else begin
                if (!bus.busy_o) busy_bad++;
                if (inject) bus.start_i = (k == 2);
                if (cen_at >= 0) cen = !(k >= cen_at && k < cen_at + 3);
                @(negedge clk);
                k++;
            end
        end
        bus.start_i = 1'b0;
        cen         = 1'b1;
        check({tag, "_we_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(k), 32'(exp_lat));
        check({tag, "_busy_during"}, 32'(busy_bad), 32'd0);
        check({tag, "_rd"}, 32'(bus.rd_o), 32'(rd));
        check({tag, "_dat"}, 32'(bus.dat_o), 32'(exp_dat));
        check({tag, "_flags"}, 32'(bus.flags_o), 32'(exp_flg));
        @(negedge clk);
        check({tag, "_we_one_cycle"}, 32'(bus.we_o), 32'd0);
        check({tag, "_idle_after"}, 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        int we_cnt;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        cen         = 1'b1;
        bus.start_i = 1'b0;
        bus.op_i    = 4'd0;
        bus.a_i     = 8'd0;
        bus.b_i     = 8'd0;
        bus.rd_i    = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_we", 32'(bus.we_o), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        check("rst_rd", 32'(bus.rd_o), 32'd0);
        check("rst_dat", 32'(bus.dat_o), 32'd0);
        check("rst_flags", 32'(bus.flags_o), 32'd0);

        // Single-cycle ops: flags are {z,c,n,v}.
        run_op("add",  4'(OP_ADD),  8'h7F, 8'h01, 3'd3, 8'h80, 4'b0011, 0, 1'b0, -1);
        run_op("sub",  4'(OP_SUB),  8'h00, 8'h01, 3'd5, 8'hFF, 4'b0110, 0, 1'b0, -1);
        run_op("and",  4'(OP_AND),  8'hF0, 8'h3C, 3'd1, 8'h30, 4'b0000, 0, 1'b0, -1);
        run_op("or",   4'(OP_OR),   8'h0F, 8'hF0, 3'd2, 8'hFF, 4'b0010, 0, 1'b0, -1);
        run_op("xor",  4'(OP_XOR),  8'hAA, 8'hAA, 3'd4, 8'h00, 4'b1000, 0, 1'b0, -1);
        run_op("shl",  4'(OP_SHL),  8'h81, 8'h00, 3'd6, 8'h02, 4'b0100, 0, 1'b0, -1);
        run_op("shr",  4'(OP_SHR),  8'h01, 8'h00, 3'd7, 8'h00, 4'b1100, 0, 1'b0, -1);
        run_op("pass", 4'(OP_PASS), 8'h11, 8'h80, 3'd0, 8'h80, 4'b0010, 0, 1'b0, -1);

        // MUL 0x12*0x34 = 0x03A8 with an extra start_i while busy.
        run_op("mul",  4'(OP_MUL),  8'h12, 8'h34, 3'd2, 8'hA8, 4'b0110, 8, 1'b1, -1);
        we_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.we_o || bus.busy_o) we_cnt++;
        end
        check("mul_no_queued_op", 32'(we_cnt), 32'd0);

        // Division family including divide by zero.
        run_op("div",    4'(OP_DIV), 8'd200, 8'd7, 3'd1, 8'd28,  4'b0000, 8, 1'b0, -1);
        run_op("mod",    4'(OP_MOD), 8'd200, 8'd7, 3'd2, 8'd4,   4'b0000, 8, 1'b0, -1);
        run_op("div0",   4'(OP_DIV), 8'h55,  8'h0, 3'd3, 8'hFF,  4'b0011, 8, 1'b0, -1);
        run_op("mod0",   4'(OP_MOD), 8'h55,  8'h0, 3'd4, 8'h55,  4'b0001, 8, 1'b0, -1);

        // Illegal opcode: err pulse only, flags/data untouched.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 4'd12;
        bus.a_i     = 8'h01;
        bus.b_i     = 8'h01;
        bus.rd_i    = 3'd6;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("ill_err", 32'(bus.err_o), 32'd1);
        check("ill_we", 32'(bus.we_o), 32'd0);
        check("ill_busy", 32'(bus.busy_o), 32'd0);
        check("ill_flags", 32'(bus.flags_o), 32'b0001);
        check("ill_dat", 32'(bus.dat_o), 32'h55);
        @(negedge clk);
        check("ill_err_pulse", 32'(bus.err_o), 32'd0);

        // DIV with cen low for 3 cycles: writeback slips by exactly 3.
        run_op("div_cen", 4'(OP_DIV), 8'd200, 8'd7, 3'd5, 8'd28, 4'b0000, 11, 1'b0, 3);

        // Reset in the middle of a MUL: immediate abort, no writeback later.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = 4'(OP_MUL);
        bus.a_i     = 8'h12;
        bus.b_i     = 8'h34;
        bus.rd_i    = 3'd7;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
        check("mid_rst_we", 32'(bus.we_o), 32'd0);
        check("mid_rst_dat", 32'(bus.dat_o), 32'd0);
        check("mid_rst_flags", 32'(bus.flags_o), 32'd0);
        check("mid_rst_rd", 32'(bus.rd_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        we_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.we_o || bus.busy_o) we_cnt++;
        end
        check("mid_rst_no_wb", 32'(we_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
